// File: rtl/inst_feeder_pkg.sv
// Shared types, constants and field helpers for the minimips instruction feeder.
// INST_FEEDER_HAZARD_EN adds the BUBBLE state used for RAW-hazard stalls.
package inst_feeder_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] inst_t;
    typedef logic [4:0]  reg_t;

    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam reg_t REG_ZERO = 5'd0;
    localparam reg_t REG_T0   = 5'd8;
    localparam reg_t REG_T1   = 5'd9;
    localparam reg_t REG_T2   = 5'd10;
    localparam reg_t REG_T3   = 5'd11;
    localparam reg_t REG_T4   = 5'd12;
    localparam reg_t REG_T7   = 5'd15;

    localparam inst_t NOP_INST = 32'h0;

    // Wide enough for BUBBLES up to 7.
    localparam int unsigned BUB_W = 3;

`ifdef INST_FEEDER_HAZARD_EN
    typedef enum logic [1:0] {StIdle, StIssue, StBubble} feed_state_e;
`else
    typedef enum logic [1:0] {StIdle, StIssue} feed_state_e;
`endif

    function automatic reg_t inst_rs(inst_t inst);
        return inst[25:21];
    endfunction

    function automatic reg_t inst_rt(inst_t inst);
        return inst[20:16];
    endfunction

endpackage

// File: rtl/inst_feeder_if.sv
// Host-side and core-side signals of the instruction feeder, bundled for port use.
// master = host/core environment, slave = the feeder itself.
interface inst_feeder_if
    import inst_feeder_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic             host_valid;
    inst_t            host_inst;
    logic             host_ready;
    logic             run;
    logic             flush;
    logic             en;
    inst_t            outer_inst;
    logic [CNT_W-1:0] issued_cnt;
    logic             empty;
    logic             full;

    modport master (
        output host_valid, host_inst, run, flush,
        input  host_ready, en, outer_inst, issued_cnt, empty, full
    );

    modport slave (
        input  host_valid, host_inst, run, flush,
        output host_ready, en, outer_inst, issued_cnt, empty, full
    );

endinterface

// File: rtl/inst_feeder_fifo.sv
// Synchronous instruction FIFO with extra pointer MSB to tell full from empty.
// The head entry is presented combinationally so the feeder can inspect it before popping.
module inst_fifo
    import inst_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  inst_t wdata,
    output inst_t head,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    inst_t       mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/inst_feeder.sv
// Instruction source for the minimips core: host-loaded FIFO feeding registered en/outer_inst.
// Define INST_FEEDER_HAZARD_EN to stall with NOP bubbles when head.rs matches the last rt.
module inst_feeder
    import inst_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned BUBBLES = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          cpu_clk_50M,
    input  logic          cpu_rst,
    inst_feeder_if.slave  bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_feeder: DEPTH must be a power of two >= 2");
    end
    if (BUBBLES < 1 || BUBBLES > 7) begin : g_bad_bubbles
        $error("inst_feeder: BUBBLES must be in 1..7");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    feed_state_e      state_q, state_d;
    logic             en_q, en_d;
    inst_t            inst_q, inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic  push, pop;
    logic  fifo_full, fifo_empty;
    inst_t head;

    // Push sees only the pre-edge full flag; flush drops a coincident push.
    assign push = bus.host_valid & ~fifo_full & ~bus.flush;

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (cpu_clk_50M),
        .rst   (cpu_rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .wdata (bus.host_inst),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef INST_FEEDER_HAZARD_EN
    localparam logic [BUB_W-1:0] BUB_ONE  = 1;
    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(BUBBLES);

    logic [BUB_W-1:0] bub_q, bub_d;
    reg_t             last_rt_q, last_rt_d;
    logic             hazard;

    assign hazard = (inst_rs(head) == last_rt_q) && (last_rt_q != REG_ZERO);
`endif

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        inst_d  = NOP_INST;
        cnt_d   = cnt_q;
        pop     = 1'b0;
`ifdef INST_FEEDER_HAZARD_EN
        bub_d     = bub_q;
        last_rt_d = last_rt_q;
`endif
        if (bus.flush) begin
            state_d = StIdle;
`ifdef INST_FEEDER_HAZARD_EN
            bub_d     = '0;
            last_rt_d = REG_ZERO;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.run) state_d = StIssue;
                end
                StIssue: begin
                    if (!bus.run) begin
                        state_d = StIdle;
                    end else if (!fifo_empty) begin
`ifdef INST_FEEDER_HAZARD_EN
                        if (hazard) begin
                            state_d = StBubble;
                            bub_d   = BUB_LOAD;
                        end else begin
                            pop       = 1'b1;
                            en_d      = 1'b1;
                            inst_d    = head;
                            cnt_d     = cnt_q + CNT_ONE;
                            last_rt_d = inst_rt(head);
                        end
`else
                        pop    = 1'b1;
                        en_d   = 1'b1;
                        inst_d = head;
                        cnt_d  = cnt_q + CNT_ONE;
`endif
                    end
                end
`ifdef INST_FEEDER_HAZARD_EN
                StBubble: begin
                    if (!bus.run) begin
                        state_d = StIdle;
                        bub_d   = '0;
                    end else begin
                        en_d  = 1'b1;
                        bub_d = bub_q - BUB_ONE;
                        if (bub_q == BUB_ONE) state_d = StIssue;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            inst_q    <= NOP_INST;
            cnt_q     <= '0;
`ifdef INST_FEEDER_HAZARD_EN
            bub_q     <= '0;
            last_rt_q <= REG_ZERO;
`endif
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            inst_q    <= inst_d;
            cnt_q     <= cnt_d;
`ifdef INST_FEEDER_HAZARD_EN
            bub_q     <= bub_d;
            last_rt_q <= last_rt_d;
`endif
        end
    end

    assign bus.en         = en_q;
    assign bus.outer_inst = inst_q;
    assign bus.issued_cnt = cnt_q;
    assign bus.empty      = fifo_empty;
    assign bus.full       = fifo_full;
    assign bus.host_ready = ~fifo_full;

endmodule

// File: tb/tb_inst_feeder.sv
// Self-checking bench for inst_feeder (default build, hazard stalls disabled).
// A queue-based reference model predicts every output after each clock edge.
module tb_inst_feeder;
    import inst_feeder_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_feeder_if #(.CNT_W(CNT_W)) bus ();

    inst_feeder #(
        .DEPTH   (DEPTH),
        .BUBBLES (2),
        .CNT_W   (CNT_W)
    ) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (bus.slave)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Reference model: queue contents, whether issuing is enabled, expected outputs.
    inst_t            mq[$];
    bit               m_issuing;
    logic [CNT_W-1:0] m_cnt;
    logic             m_en;
    inst_t            m_inst;

    typedef struct {
        logic             valid;
        inst_t            inst;
        logic             run;
        logic             flush;
        logic             exp_en;
        inst_t            exp_inst;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_empty;
    } vec_t;

    vec_t tbl[7];

    function automatic inst_t addi(reg_t rs, reg_t rt, logic [15:0] imm);
        return {OP_ADDI, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_issuing = 1'b0;
        m_cnt     = '0;
        m_en      = 1'b0;
        m_inst    = NOP_INST;
    endtask

    task automatic check_model();
        chk("en", 32'(bus.en), 32'(m_en));
        chk("outer_inst", bus.outer_inst, m_inst);
        chk("issued_cnt", 32'(bus.issued_cnt), 32'(m_cnt));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("host_ready", 32'(bus.host_ready), 32'(mq.size() != DEPTH));
    endtask

    // One clock: drive inputs, advance the model from pre-edge state, compare after the edge.
    task automatic step(input logic v, input inst_t i, input logic r, input logic f);
        bit full_pre, empty_pre;
        bus.host_valid = v;
        bus.host_inst  = i;
        bus.run        = r;
        bus.flush      = f;
        full_pre  = (mq.size() == DEPTH);
        empty_pre = (mq.size() == 0);
        if (f) begin
            mq.delete();
            m_issuing = 1'b0;
            m_en      = 1'b0;
            m_inst    = NOP_INST;
        end else begin
            if (m_issuing && r && !empty_pre) begin
                m_inst = mq.pop_front();
                m_en   = 1'b1;
                m_cnt  = m_cnt + 1'b1;
            end else begin
                m_en   = 1'b0;
                m_inst = NOP_INST;
            end
            if (v && !full_pre) mq.push_back(i);
            m_issuing = r;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] base;
        int               pushed;
        inst_t            i1, i2, i3, i4;

        bus.host_valid = 1'b0;
        bus.host_inst  = NOP_INST;
        bus.run        = 1'b0;
        bus.flush      = 1'b0;
        rst            = 1'b1;
        model_reset();

        // Reset held 10 ns, released with run low.
        #10;
        rst = 1'b0;
        #2;
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_inst", bus.outer_inst, 32'h0);
        chk("rst_ready", 32'(bus.host_ready), 32'd1);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_cnt", 32'(bus.issued_cnt), 32'd0);

        // Streaming four independent ADDIs.
        i1 = addi(REG_T0, REG_T1, 16'd127);
        i2 = addi(REG_T0, REG_T2, 16'd127);
        i3 = addi(REG_T0, REG_T3, 16'd127);
        i4 = addi(REG_T0, REG_T4, 16'd127);
        tbl[0] = '{1'b0, NOP_INST, 1'b1, 1'b0, 1'b0, NOP_INST, 16'd0, 1'b1};
        tbl[1] = '{1'b1, i1,       1'b1, 1'b0, 1'b0, NOP_INST, 16'd0, 1'b0};
        tbl[2] = '{1'b1, i2,       1'b1, 1'b0, 1'b1, i1,       16'd1, 1'b0};
        tbl[3] = '{1'b1, i3,       1'b1, 1'b0, 1'b1, i2,       16'd2, 1'b0};
        tbl[4] = '{1'b1, i4,       1'b1, 1'b0, 1'b1, i3,       16'd3, 1'b0};
        tbl[5] = '{1'b0, NOP_INST, 1'b1, 1'b0, 1'b1, i4,       16'd4, 1'b1};
        tbl[6] = '{1'b0, NOP_INST, 1'b1, 1'b0, 1'b0, NOP_INST, 16'd4, 1'b1};
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].valid, tbl[k].inst, tbl[k].run, tbl[k].flush);
            chk($sformatf("tbl%0d_en", k), 32'(bus.en), 32'(tbl[k].exp_en));
            chk($sformatf("tbl%0d_inst", k), bus.outer_inst, tbl[k].exp_inst);
            chk($sformatf("tbl%0d_cnt", k), 32'(bus.issued_cnt), 32'(tbl[k].exp_cnt));
            chk($sformatf("tbl%0d_empty", k), 32'(bus.empty), 32'(tbl[k].exp_empty));
        end

        // Fill to full with run low; a ninth offer must be refused.
        step(1'b0, NOP_INST, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, inst_t'(32'hA000_0000 + k), 1'b0, 1'b0);
        chk("full_flag", 32'(bus.full), 32'd1);
        chk("full_ready", 32'(bus.host_ready), 32'd0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        base = bus.issued_cnt;
        // First run edge moves to issuing; push offered while full and popping is still refused.
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        step(1'b1, 32'hBAD0_0001, 1'b1, 1'b0);
        chk("full_drop_first", bus.outer_inst, 32'hA000_0000);
        chk("full_after_pop", 32'(bus.full), 32'd0);
        for (int k = 0; k < 9; k++) step(1'b0, NOP_INST, 1'b1, 1'b0);
        chk("full_drained_cnt", 32'(bus.issued_cnt - base), 32'd8);
        chk("full_drained_en", 32'(bus.en), 32'd0);

        // Twenty pushes with run toggling across pointer wrap.
        base   = bus.issued_cnt;
        pushed = 0;
        for (int k = 0; k < 200 && (pushed < 20 || mq.size() != 0); k++) begin
            logic v;
            v = (pushed < 20);
            if (v && mq.size() != DEPTH) pushed++;
            step(v, inst_t'(32'hC000_0000 + pushed), ((k / 3) % 2) == 0 || pushed >= 20,
                 1'b0);
        end
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        chk("wrap_cnt", 32'(bus.issued_cnt - base), 32'd20);

        // Flush mid-stream: five queued, two issued, push in flush cycle lost.
        step(1'b0, NOP_INST, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, inst_t'(32'hF000_0000 + k), 1'b0, 1'b0);
        base = bus.issued_cnt;
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        chk("flush_pre_cnt", 32'(bus.issued_cnt - base), 32'd2);
        step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
        chk("flush_en", 32'(bus.en), 32'd0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("flush_cnt", 32'(bus.issued_cnt - base), 32'd2);
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        chk("flush_no_issue", 32'(bus.en), 32'd0);

        // Dependent pair issues back-to-back without hazard stalls.
        step(1'b1, addi(REG_T0, REG_T7, 16'd1), 1'b1, 1'b0);
        step(1'b1, addi(REG_T7, REG_T0, 16'd2), 1'b1, 1'b0);
        chk("dep_first", bus.outer_inst, addi(REG_T0, REG_T7, 16'd1));
        step(1'b0, NOP_INST, 1'b1, 1'b0);
        chk("dep_second", bus.outer_inst, addi(REG_T7, REG_T0, 16'd2));

        // Asynchronous reset mid-operation.
        for (int k = 0; k < 4; k++) step(1'b1, inst_t'($urandom), 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en", 32'(bus.en), 32'd0);
        chk("arst_inst", bus.outer_inst, 32'h0);
        chk("arst_cnt", 32'(bus.issued_cnt), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        bus.host_valid = 1'b0;
        bus.run        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step(($urandom % 4) != 0, inst_t'($urandom), ($urandom % 6) != 0,
                 ($urandom % 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
